// File: rtl/neuron_pkg.sv
// Shared constants, state encoding and helpers for the neuron layer collector.
// Defaults describe a 4-neuron layer, Q8.8 results requantized to Q4.4.
package neuron_pkg;

    localparam int NUM_NEURONS_D = 4;
    localparam int IN_W_D        = 16;
    localparam int IN_FRAC_D     = 8;
    localparam int Y_W_D         = 8;
    localparam int Y_FRAC_D      = 4;

    // Index width for n slots; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int SHIFT = IN_FRAC_D - Y_FRAC_D;
    localparam int Y_MAX = (2 ** (Y_W_D - 1)) - 1;
    localparam int Y_MIN = -(2 ** (Y_W_D - 1));
    localparam int IDX_W = idx_width(NUM_NEURONS_D);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } collect_state_t;

endpackage

// File: rtl/neuron_requant_sat.sv
// Combinational requantizer: round half up, arithmetic shift by
// IN_FRAC-Y_FRAC, then saturate to the signed Y_W range.
// Ports: in_data (signed IN_W) -> y (signed Y_W), sat (value was clamped).
module neuron_requant_sat
    import neuron_pkg::*;
#(
    parameter int IN_W    = IN_W_D,
    parameter int IN_FRAC = IN_FRAC_D,
    parameter int Y_W     = Y_W_D,
    parameter int Y_FRAC  = Y_FRAC_D
) (
    input  logic [IN_W-1:0] in_data,
    output logic [Y_W-1:0]  y,
    output logic            sat
);

    localparam int SH = IN_FRAC - Y_FRAC;
    localparam int W  = IN_W + 1;

    // One guard bit so adding the rounding half can never wrap.
    localparam logic signed [W-1:0] HI = W'((1 << (Y_W - 1)) - 1);
    localparam logic signed [W-1:0] LO = ~HI;

    logic signed [W-1:0] ext;
    logic signed [W-1:0] t;

    assign ext = {in_data[IN_W-1], in_data};

    generate
        if (SH > 0) begin : g_round
            localparam logic signed [W-1:0] HALF = W'(1) << (SH - 1);
            assign t = (ext + HALF) >>> SH;
        end else begin : g_pass
            assign t = ext;
        end
    endgenerate

    always_comb begin
        y   = t[Y_W-1:0];
        sat = 1'b0;
        if (t > HI) begin
            y   = HI[Y_W-1:0];
            sat = 1'b1;
        end else if (t < LO) begin
            y   = LO[Y_W-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/neuron_layer_collector.sv
// Collects NUM_NEURONS requantized neuron results into one flat vector
// and hands it downstream with valid/ready backpressure.
// Ports: in_valid/in_ready/in_data (result stream), out_valid/out_ready/
// y_flat (packed vector), out_sat (any element clamped), out_argmax
// (index of largest raw result), busy (partial or pending vector).
// Optional: define NEURON_COLLECT_ARGMAX_EN to track the argmax.
module neuron_layer_collector
    import neuron_pkg::*;
#(
    parameter int NUM_NEURONS = NUM_NEURONS_D,
    parameter int IN_W        = IN_W_D,
    parameter int IN_FRAC     = IN_FRAC_D,
    parameter int Y_W         = Y_W_D,
    parameter int Y_FRAC      = Y_FRAC_D,
    localparam int CNT_W      = idx_width(NUM_NEURONS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_W-1:0]          in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_NEURONS*Y_W-1:0] y_flat,
    output logic                     out_sat,
    output logic [CNT_W-1:0]         out_argmax,
    output logic                     busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_NEURONS - 1);

    collect_state_t   state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             take;

    logic [Y_W-1:0]   y_q [NUM_NEURONS];
    logic             sat_q;
    logic [Y_W-1:0]   y_req;
    logic             el_sat;

    neuron_requant_sat #(
        .IN_W    (IN_W),
        .IN_FRAC (IN_FRAC),
        .Y_W     (Y_W),
        .Y_FRAC  (Y_FRAC)
    ) u_requant (
        .in_data (in_data),
        .y       (y_req),
        .sat     (el_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        in_ready = 1'b0;
        take     = 1'b0;
        unique case (state_q)
            COLLECT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    take = 1'b1;
                    if (count_q == LAST) begin
                        state_d = HOLD;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                // No bypass: in_ready only returns after this edge.
                if (out_ready) begin
                    state_d = COLLECT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                y_q[i] <= '0;
            end
            sat_q <= 1'b0;
        end else if (take) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (count_q == CNT_W'(i)) begin
                    y_q[i] <= y_req;
                end
            end
            // First element of a vector starts a fresh saturation flag.
            sat_q <= (count_q == '0) ? el_sat : (sat_q | el_sat);
        end
    end

`ifdef NEURON_COLLECT_ARGMAX_EN
    logic signed [IN_W-1:0] max_q;
    logic [CNT_W-1:0]       arg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_q <= '0;
            arg_q <= '0;
        end else if (take) begin
            // Strict compare keeps the lowest index on ties.
            if ((count_q == '0) || ($signed(in_data) > max_q)) begin
                max_q <= $signed(in_data);
                arg_q <= count_q;
            end
        end
    end

    assign out_argmax = arg_q;
`else
    assign out_argmax = '0;
`endif

    generate
        for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_flat
            assign y_flat[g*Y_W +: Y_W] = y_q[g];
        end
    endgenerate

    assign out_valid = (state_q == HOLD);
    assign out_sat   = sat_q;
    assign busy      = (count_q != '0) || (state_q == HOLD);

endmodule

// File: tb/tb_neuron_layer_collector.sv
// Randomized and directed bench for neuron_layer_collector with a
// behavioural vector model checked every cycle.
module tb_neuron_layer_collector;

    localparam int N       = 4;
    localparam int IN_W    = 16;
    localparam int IN_FRAC = 8;
    localparam int Y_W     = 8;
    localparam int Y_FRAC  = 4;
    localparam int SH      = IN_FRAC - Y_FRAC;
    localparam int AW      = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [IN_W-1:0] in_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [N*Y_W-1:0] y_flat;
    logic            out_sat;
    logic [AW-1:0]   out_argmax;
    logic            busy;

    neuron_layer_collector #(
        .NUM_NEURONS (N),
        .IN_W        (IN_W),
        .IN_FRAC     (IN_FRAC),
        .Y_W         (Y_W),
        .Y_FRAC      (Y_FRAC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y_flat     (y_flat),
        .out_sat    (out_sat),
        .out_argmax (out_argmax),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int pend[$];
    int vec[N];
    bit have = 0;

    function automatic int rq_raw(input int x);
        int d, t;
        d = 1 << SH;
        t = x + d / 2;
        return (t >= 0) ? t / d : -((-t + d - 1) / d);
    endfunction

    function automatic int rq(input int x);
        int v;
        v = rq_raw(x);
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v;
    endfunction

    function automatic logic [N*Y_W-1:0] exp_y();
        logic [N*Y_W-1:0] e;
        for (int i = 0; i < N; i++) e[i*Y_W +: Y_W] = Y_W'(rq(vec[i]));
        return e;
    endfunction

    function automatic logic exp_sat();
        logic s;
        s = 1'b0;
        for (int i = 0; i < N; i++) if (rq(vec[i]) != rq_raw(vec[i])) s = 1'b1;
        return s;
    endfunction

    function automatic logic [AW-1:0] exp_arg();
`ifdef NEURON_COLLECT_ARGMAX_EN
        int b;
        b = 0;
        for (int i = 1; i < N; i++) if (vec[i] > vec[b]) b = i;
        return AW'(b);
`else
        return '0;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend.delete();
            have = 0;
        end else if (have) begin
            if (out_ready) have = 0;
        end else if (in_valid) begin
            pend.push_back(int'($signed(in_data)));
            if (pend.size() == N) begin
                for (int i = 0; i < N; i++) vec[i] = pend[i];
                pend.delete();
                have = 1;
            end
        end
    end

    bit mon = 0;

    always @(negedge clk) begin
        if (mon && !rst) begin
            chk("in_ready", in_ready, have ? 1'b0 : 1'b1);
            chk("out_valid", out_valid, have);
            chk("busy", busy, (have || pend.size() > 0) ? 1'b1 : 1'b0);
            if (have) begin
                chk("y_flat", y_flat, exp_y());
                chk("out_sat", out_sat, exp_sat());
                chk("out_argmax", out_argmax, exp_arg());
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send(input logic [IN_W-1:0] v, input int gap);
        bit r;
        int n;
        in_valid = 1'b1;
        in_data  = v;
        n = 0;
        while (1) begin
            r = in_ready;
            @(negedge clk);
            if (r) break;
            n++;
            if (n > 50) begin
                chk("send_timeout", 1, 0);
                break;
            end
        end
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send4(input logic [IN_W-1:0] a, b, c, d, input int gap);
        send(a, gap);
        send(b, gap);
        send(c, gap);
        send(d, 0);
    endtask

    task automatic consume();
        bit r;
        int n;
        out_ready = 1'b1;
        n = 0;
        while (1) begin
            r = out_valid;
            @(negedge clk);
            if (r) break;
            n++;
            if (n > 50) begin
                chk("consume_timeout", 1, 0);
                break;
            end
        end
        out_ready = 1'b0;
    endtask

    logic [N*Y_W-1:0] y0;

    initial begin
        chk("model_rq_pos", rq(291), 18);
        chk("model_rq_neg", rq(-24), -1);
        chk("model_rq_sat", rq(-32768), -128);

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_y_flat", y_flat, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_argmax", out_argmax, 0);
        rst = 1'b0;
        mon = 1;
        @(negedge clk);

        // basic pack and latency
        send4(16'h0123, 16'h0018, 16'h0008, 16'h0007, 0);
        chk("basic_latency", out_valid, 1);
        chk("basic_y", y_flat, 32'h0001_0212);
        chk("basic_sat", out_sat, 0);
        consume();

        // saturation, then a clean vector clears the flag
        send4(16'h7FFF, 16'h8000, 16'hFFE8, 16'h0000, 0);
        chk("sat_y", y_flat, 32'h00FF_807F);
        chk("sat_flag", out_sat, 1);
        consume();
        send4(16'h0123, 16'h0018, 16'h0008, 16'h0007, 0);
        chk("sat_clear", out_sat, 0);

        // backpressure with ignored input pulses
        y0 = y_flat;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom % 2);
            in_data  = IN_W'($urandom);
            @(negedge clk);
            chk("bp_stable", y_flat, y0);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);

        // stalled upstream gives the same vector
        send4(16'h0123, 16'h0018, 16'h0008, 16'h0007, 3);
        chk("stall_y", y_flat, 32'h0001_0212);
        chk("stall_busy", busy, 1);
        consume();

        // argmax with a tie
        send4(16'h0010, 16'h0200, 16'h0200, 16'hFF00, 0);
`ifdef NEURON_COLLECT_ARGMAX_EN
        chk("argmax", out_argmax, 1);
`else
        chk("argmax", out_argmax, 0);
`endif
        consume();

        // asynchronous reset after two accepts
        send(16'h0400, 0);
        send(16'h0500, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_y", y_flat, 0);
        chk("arst_ready", in_ready, 1);
        chk("arst_sat", out_sat, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send4(16'h0123, 16'h0018, 16'h0008, 16'h0007, 0);
        chk("arst_fresh_y", y_flat, 32'h0001_0212);
        consume();

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            in_valid = 1'(($urandom % 3) != 0);
            if ($urandom % 4 == 0) in_data = IN_W'($urandom);
            else in_data = IN_W'(int'($urandom_range(4200)) - 2100);
            out_ready = 1'($urandom % 2);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
